// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory byte-stream loader.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } loader_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_SUM     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // A frame is good when the data bytes plus the checksum byte wrap to zero.
  function automatic logic frame_sum_ok(input logic [7:0] sum, input logic [7:0] chk);
    logic [7:0] total;
    total = sum + chk;
    return (total == 8'd0);
  endfunction

endpackage

// File: rtl/instr_mem_loader_gap_timer.sv
// Idle-gap watchdog: counts cycles without a handshake while enabled and
// flags expiry in the cycle that completes TIMEOUT_CYCLES idle cycles.
module loader_gap_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_r;

  // Idle counter; saturates at LAST so a missed expiry never wraps to zero.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_r <= {CW{1'b0}};
    end else if (clear) begin
      count_r <= {CW{1'b0}};
    end else if (enable && (count_r != LAST)) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = enable && (count_r == LAST);

endmodule

// File: rtl/instr_mem_loader.sv
// Framed byte-stream loader for the 128-byte instruction memory: SYNC, length,
// data, checksum. Holds the CPU while a load is in progress.
module instr_mem_loader
  import instr_loader_pkg::*;
#(
  parameter int         MEM_BYTES      = 128,
  parameter int         ADDR_WIDTH     = 16,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic [7:0]            InByte,
  input  logic                  InValid,
  output logic                  InReady,
  output logic                  MemWrEn,
  output logic [ADDR_WIDTH-1:0] MemWrAddr,
  output logic [7:0]            MemWrData,
  output logic                  CpuHold,
  output logic                  LoadDone,
  output logic                  LoadError,
  output logic [1:0]            ErrorCode
);

  localparam logic [8:0] MAX_LEN = 9'(MEM_BYTES);

  loader_state_e         state_r, state_s;
  logic [7:0]            len_r, len_s;
  logic [7:0]            addr_r, addr_s;
  logic [7:0]            sum_r, sum_s;
  logic                  wr_en_r, wr_en_s;
  logic [ADDR_WIDTH-1:0] wr_addr_r, wr_addr_s;
  logic [7:0]            wr_data_r, wr_data_s;
  logic                  hold_r, hold_s;
  logic                  done_r, done_s;
  logic                  err_r, err_s;
  logic [1:0]            code_r, code_s;

  logic ready_s;
  logic hs_s;
  logic timer_en_s;
  logic timer_clr_s;
  logic expire_s;

  // Per-state decode of stream readiness and gap-timer activity.
  always_comb begin
    ready_s    = 1'b0;
    timer_en_s = 1'b0;
    case (state_r)
      IDLE:              begin ready_s = 1'b1; timer_en_s = 1'b0; end
      LEN, DATA, CHECK:  begin ready_s = 1'b1; timer_en_s = 1'b1; end
      DONE, ERR:         begin ready_s = 1'b0; timer_en_s = 1'b0; end
      default:           begin ready_s = 1'b0; timer_en_s = 1'b0; end
    endcase
  end

  assign hs_s        = InValid & ready_s;
  // Leaving the active states keeps the timer at zero, so entry to LEN starts clean.
  assign timer_clr_s = hs_s | ~timer_en_s;

  loader_gap_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk    (Clock),
    .resetn (ResetN),
    .clear  (timer_clr_s),
    .enable (timer_en_s),
    .expire (expire_s)
  );

  // Next-state and next-register values; a handshake always beats timer expiry.
  always_comb begin
    state_s   = state_r;
    len_s     = len_r;
    addr_s    = addr_r;
    sum_s     = sum_r;
    wr_en_s   = 1'b0;
    wr_addr_s = wr_addr_r;
    wr_data_s = wr_data_r;
    hold_s    = hold_r;
    done_s    = 1'b0;
    err_s     = err_r;
    code_s    = code_r;
    case (state_r)
      IDLE: begin
        if (hs_s && (InByte == SYNC_BYTE)) begin
          state_s = LEN;
          hold_s  = 1'b1;
          err_s   = 1'b0;
          code_s  = ERR_NONE;
        end else begin
          state_s = IDLE;
        end
      end
      LEN: begin
        if (hs_s) begin
          if ((InByte == 8'd0) || ({1'b0, InByte} > MAX_LEN)) begin
            state_s = ERR;
            err_s   = 1'b1;
            code_s  = ERR_LEN;
          end else begin
            len_s   = InByte;
            addr_s  = 8'd0;
            sum_s   = 8'd0;
            state_s = DATA;
          end
        end else if (expire_s) begin
          state_s = ERR;
          err_s   = 1'b1;
          code_s  = ERR_TIMEOUT;
        end else begin
          state_s = LEN;
        end
      end
      DATA: begin
        if (hs_s) begin
          wr_en_s   = 1'b1;
          wr_addr_s = ADDR_WIDTH'(addr_r);
          wr_data_s = InByte;
          addr_s    = addr_r + 8'd1;
          sum_s     = sum_r + InByte;
          if ((addr_r + 8'd1) == len_r) begin
            state_s = CHECK;
          end else begin
            state_s = DATA;
          end
        end else if (expire_s) begin
          state_s = ERR;
          err_s   = 1'b1;
          code_s  = ERR_TIMEOUT;
        end else begin
          state_s = DATA;
        end
      end
      CHECK: begin
        if (hs_s) begin
          if (frame_sum_ok(sum_r, InByte)) begin
            state_s = DONE;
            done_s  = 1'b1;
            hold_s  = 1'b0;
          end else begin
            state_s = ERR;
            err_s   = 1'b1;
            code_s  = ERR_SUM;
          end
        end else if (expire_s) begin
          state_s = ERR;
          err_s   = 1'b1;
          code_s  = ERR_TIMEOUT;
        end else begin
          state_s = CHECK;
        end
      end
      DONE:    state_s = IDLE;
      ERR:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State and output registers; reset abandons any frame without touching memory.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_r   <= IDLE;
      len_r     <= 8'd0;
      addr_r    <= 8'd0;
      sum_r     <= 8'd0;
      wr_en_r   <= 1'b0;
      wr_addr_r <= {ADDR_WIDTH{1'b0}};
      wr_data_r <= 8'd0;
      hold_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      code_r    <= ERR_NONE;
    end else begin
      state_r   <= state_s;
      len_r     <= len_s;
      addr_r    <= addr_s;
      sum_r     <= sum_s;
      wr_en_r   <= wr_en_s;
      wr_addr_r <= wr_addr_s;
      wr_data_r <= wr_data_s;
      hold_r    <= hold_s;
      done_r    <= done_s;
      err_r     <= err_s;
      code_r    <= code_s;
    end
  end

  assign InReady   = ready_s;
  assign MemWrEn   = wr_en_r;
  assign MemWrAddr = wr_addr_r;
  assign MemWrData = wr_data_r;
  assign CpuHold   = hold_r;
  assign LoadDone  = done_r;
  assign LoadError = err_r;
  assign ErrorCode = code_r;

endmodule
